regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next-generation register file for the pipelined RV32 core:
- N read ports and M write ports, for example ALU writeback and load writeback.
- Same-cycle write-to-read bypass and a hardwired zero register.
- A busy bit per register, set at issue and cleared at writeback, so the hazard unit can stall on pending producers.

Parameters:
XLEN, 32, register data width in bits
NUM_REGS, 32, number of architectural registers (power of two, ≥2)
AW, $clog2(NUM_REGS), address width; localparam, not overridable
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..3); higher index has higher priority
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = return stored value only
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and never becomes busy

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
rs_addr_i  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
rs_data_o  out  NUM_RD*XLEN  read data, combinational
rs_busy_o  out  NUM_RD  1 = register at rs_addr has a pending producer
wr_en_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR*AW  write addresses
wr_data_i  in  NUM_WR*XLEN  write data
issue_en_i  in  1  an instruction with a destination register issues this cycle
issue_addr_i  in  AW  destination register of the issuing instruction
flush_i  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset: clk_i is the only clock; reset is synchronous and active-high on rst_i.
  - At the rising edge with rst_i=1, all registers and all busy bits become 0.
  - While rst_i=1, writes and issues are ignored, and rs_data_o and rs_busy_o are forced to 0.
- Write resolution:
  - Effective write j = wr_en_i[j] and not (ZERO_REG and wr_addr==0).
  - If several effective writes target the same address, the highest j wins for both storage and bypass.
  - Writes to distinct addresses all commit in the same edge.
- Read, combinational, zero cycles:
  - If ZERO_REG and addr==0, the port returns 0.
  - Else if BYPASS and an effective write hits addr, it returns the winning wr_data.
  - Else it returns the stored register.
- Busy, next state per register r:
  - If flush_i: 0.
  - Else if issue_en_i and issue_addr==r (r≠0 when ZERO_REG): 1. A same-cycle issue takes precedence over a same-cycle write.
  - Else if any effective write hits r: 0.
  - Else: hold.
- rs_busy_o[k]:
  - Equals busy[addr] AND NOT (an effective write hits addr this cycle).
  - When BYPASS=0 the AND NOT term is dropped; a value being written the same cycle still reports busy until the next edge.
  - It is 0 for register 0 when ZERO_REG.
- flush_i does not block writes; data still commits.
- No stall or back-pressure inside the block; all accepts are unconditional.
- Busy updates are combinational-in, registered-out: an issue at edge t makes rs_busy_o high from cycle t+1.
- Address out of range cannot occur, because NUM_REGS is a power of two.

Decomposition:
- Shared package/header, the existing core defines header: XLEN, NUM_REGS, register-address width, and the zero-register index constant.
- Sub-module regfile_read_port, instantiated NUM_RD times. Inputs: one address, the storage array view, busy vector, and write buses. Outputs: data and busy. It contains the zero check, priority-encoded bypass mux and busy masking.
- Write and scoreboard logic stays in the top module.

Test Plan:
1. Reset then read: hold rst_i=1 for 2 cycles, release, read x5 on both ports -> rs_data_o=0 and rs_busy_o=0 on both ports.
2. Write/bypass: wr_en[0], addr 5, data 0xDEADBEEF; same cycle rs_addr0=5 -> rs_data0=0xDEADBEEF that cycle. Next cycle with no write -> still 0xDEADBEEF.
3. Zero register: write 0x1234 to x0 and issue to x0 -> reads of x0 return 0 and busy stays 0.
4. Write conflict: wr0 = (x7, 0x11) and wr1 = (x7, 0x22) same cycle -> bypass 0x22, stored 0x22. wr0 = (x3, 0xA) with wr1 = (x4, 0xB) -> both stored.
5. Scoreboard, four stimulus steps:
   - Issue x9 -> busy(x9)=1 next cycle.
   - Write x9 -> busy reads 0 in the write cycle (BYPASS=1) and stays 0 after.
   - Issue x9 and write x9 in the same cycle -> busy=1 afterwards.
   - Flush with busy x2 and x9 set -> both 0 next cycle.
6. Mid-operation reset: registers x1..x4 hold nonzero values, x2 busy; assert rst_i with a write to x1 in the same cycle -> after the edge all reads are 0, busy is 0, and the write is dropped.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared core definitions for the multi-port register file: architectural
// sizes and the index of the hardwired zero register.
package regfile_mp_sb_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int ZERO_IDX = 0;

endpackage : regfile_mp_sb_pkg

// File: rtl/regfile_mp_sb_if.sv
// Bus bundle between the pipeline (master) and the register file (slave):
// read ports, write ports, issue and flush.
interface regfile_mp_sb_if #(
    parameter int XLEN     = regfile_mp_sb_pkg::XLEN,
    parameter int NUM_REGS = regfile_mp_sb_pkg::NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]   rs_addr_i;
    logic [NUM_RD*XLEN-1:0] rs_data_o;
    logic [NUM_RD-1:0]      rs_busy_o;
    logic [NUM_WR-1:0]      wr_en_i;
    logic [NUM_WR*AW-1:0]   wr_addr_i;
    logic [NUM_WR*XLEN-1:0] wr_data_i;
    logic                   issue_en_i;
    logic [AW-1:0]          issue_addr_i;
    logic                   flush_i;

    modport master (
        output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_en_i, issue_addr_i, flush_i,
        input  rs_data_o, rs_busy_o
    );

    modport slave (
        input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_en_i, issue_addr_i, flush_i,
        output rs_data_o, rs_busy_o
    );

endinterface : regfile_mp_sb_if

// File: rtl/regfile_mp_sb_read_port.sv
// One combinational read port: zero-register check, priority bypass from the
// write buses, and busy masking when the producer writes back this cycle.
module regfile_read_port
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN     = regfile_mp_sb_pkg::XLEN,
    parameter int NUM_REGS = regfile_mp_sb_pkg::NUM_REGS,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                           rst,
    input  logic [AW-1:0]                  addr,
    input  logic [NUM_REGS-1:0][XLEN-1:0]  regs,
    input  logic [NUM_REGS-1:0]            busy,
    input  logic [NUM_WR-1:0]              eff_wr,
    input  logic [NUM_WR*AW-1:0]           wr_addr,
    input  logic [NUM_WR*XLEN-1:0]         wr_data,
    output logic [XLEN-1:0]                data,
    output logic                           pending
);

    logic            hit;
    logic [XLEN-1:0] hit_data;
    logic            is_zero;

    // Find the write hitting this address; later ports overwrite earlier ones so the highest index wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (eff_wr[j] && (wr_addr[j*AW +: AW] == addr)) begin
                hit      = 1'b1;
                hit_data = wr_data[j*XLEN +: XLEN];
            end
        end
    end

    // Select read data and busy status, forcing zeros during reset and for the zero register
    always_comb begin
        is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));
        data    = '0;
        pending = 1'b0;
        if (!rst && !is_zero) begin
            if ((BYPASS != 0) && hit) begin
                data = hit_data;
            end else begin
                data = regs[addr];
            end
            pending = busy[addr] && !((BYPASS != 0) && hit);
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Writes resolve by port priority; busy is set at issue, cleared at writeback.
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN     = regfile_mp_sb_pkg::XLEN,
    parameter int NUM_REGS = regfile_mp_sb_pkg::NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input logic             clk_i,
    input logic             rst_i,
    regfile_mp_sb_if.slave  bus
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs;
    logic [NUM_REGS-1:0]           busy;
    logic [NUM_REGS-1:0]           busy_next;
    logic [NUM_WR-1:0]             eff_wr;
    logic                          eff_issue;

    // A write is effective unless it targets the hardwired zero register
    always_comb begin
        eff_wr = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            eff_wr[j] = bus.wr_en_i[j] &&
                        !((ZERO_REG != 0) && (bus.wr_addr_i[j*AW +: AW] == AW'(ZERO_IDX)));
        end
        eff_issue = bus.issue_en_i &&
                    !((ZERO_REG != 0) && (bus.issue_addr_i == AW'(ZERO_IDX)));
    end

    // Scoreboard next state: writeback clears, issue sets over writeback, flush clears everything
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (eff_wr[j]) begin
                busy_next[bus.wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (eff_issue) begin
            busy_next[bus.issue_addr_i] = 1'b1;
        end
        if (bus.flush_i) begin
            busy_next = '0;
        end
    end

    // Commit writes in port order so the highest-index port wins a same-address conflict
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (eff_wr[j]) begin
                    regs[bus.wr_addr_i[j*AW +: AW]] <= bus.wr_data_i[j*XLEN +: XLEN];
                end
            end
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_read_port (
            .rst     (rst_i),
            .addr    (bus.rs_addr_i[k*AW +: AW]),
            .regs    (regs),
            .busy    (busy),
            .eff_wr  (eff_wr),
            .wr_addr (bus.wr_addr_i),
            .wr_data (bus.wr_data_i),
            .data    (bus.rs_data_o[k*XLEN +: XLEN]),
            .pending (bus.rs_busy_o[k])
        );
    end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb: reset, bypass, zero register,
// write conflicts, scoreboard and mid-operation reset.
module tb_regfile_mp_sb;
    import regfile_mp_sb_pkg::*;

    localparam int AW = REG_AW;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    regfile_mp_sb_if #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(2), .NUM_WR(2)
    ) bus ();

    regfile_mp_sb #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.wr_en_i      = '0;
        bus.wr_addr_i    = '0;
        bus.wr_data_i    = '0;
        bus.issue_en_i   = 1'b0;
        bus.issue_addr_i = '0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic setRead(input int k, input int addr);
        bus.rs_addr_i[k*AW +: AW] = AW'(addr);
    endtask

    task automatic setWrite(input int j, input int addr, input logic [31:0] data);
        bus.wr_en_i[j]              = 1'b1;
        bus.wr_addr_i[j*AW +: AW]   = AW'(addr);
        bus.wr_data_i[j*XLEN +: XLEN] = data;
    endtask

    task automatic setIssue(input int addr);
        bus.issue_en_i   = 1'b1;
        bus.issue_addr_i = AW'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdData(input int k);
        return bus.rs_data_o[k*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] rdBusy(input int k);
        return {31'b0, bus.rs_busy_o[k]};
    endfunction

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        bus.rs_addr_i = '0;
        applyStimulus();

        // 1: reset then read x5
        tick();
        tick();
        rst = 1'b0;
        setRead(0, 5);
        setRead(1, 5);
        #1;
        checkOutput("reset_data0", rdData(0), 32'h0);
        checkOutput("reset_data1", rdData(1), 32'h0);
        checkOutput("reset_busy0", rdBusy(0), 32'h0);
        checkOutput("reset_busy1", rdBusy(1), 32'h0);

        // 2: write with same-cycle bypass, then stored value
        setWrite(0, 5, 32'hDEADBEEF);
        #1;
        checkOutput("bypass_x5", rdData(0), 32'hDEADBEEF);
        tick();
        applyStimulus();
        #1;
        checkOutput("stored_x5_p0", rdData(0), 32'hDEADBEEF);
        checkOutput("stored_x5_p1", rdData(1), 32'hDEADBEEF);

        // 3: zero register ignores writes and issues
        setRead(0, 0);
        setWrite(0, 0, 32'h1234);
        setIssue(0);
        #1;
        checkOutput("x0_bypass", rdData(0), 32'h0);
        checkOutput("x0_busy_now", rdBusy(0), 32'h0);
        tick();
        applyStimulus();
        #1;
        checkOutput("x0_data", rdData(0), 32'h0);
        checkOutput("x0_busy", rdBusy(0), 32'h0);

        // 4: same-address conflict, then distinct addresses
        setRead(0, 7);
        setWrite(0, 7, 32'h11);
        setWrite(1, 7, 32'h22);
        #1;
        checkOutput("conflict_bypass", rdData(0), 32'h22);
        tick();
        applyStimulus();
        #1;
        checkOutput("conflict_stored", rdData(0), 32'h22);
        setWrite(0, 3, 32'hA);
        setWrite(1, 4, 32'hB);
        tick();
        applyStimulus();
        setRead(0, 3);
        setRead(1, 4);
        #1;
        checkOutput("dual_x3", rdData(0), 32'hA);
        checkOutput("dual_x4", rdData(1), 32'hB);

        // 5: scoreboard
        setRead(0, 9);
        setRead(1, 2);
        setIssue(9);
        #1;
        checkOutput("issue_x9_same_cycle", rdBusy(0), 32'h0);
        tick();
        applyStimulus();
        #1;
        checkOutput("issue_x9_busy", rdBusy(0), 32'h1);
        setWrite(1, 9, 32'h99);
        #1;
        checkOutput("wb_x9_masked", rdBusy(0), 32'h0);
        checkOutput("wb_x9_bypass", rdData(0), 32'h99);
        tick();
        applyStimulus();
        #1;
        checkOutput("wb_x9_cleared", rdBusy(0), 32'h0);
        setIssue(9);
        setWrite(0, 9, 32'h55);
        tick();
        applyStimulus();
        #1;
        checkOutput("issue_wins_busy", rdBusy(0), 32'h1);
        checkOutput("issue_wins_data", rdData(0), 32'h55);
        setIssue(2);
        tick();
        applyStimulus();
        #1;
        checkOutput("pre_flush_x9", rdBusy(0), 32'h1);
        checkOutput("pre_flush_x2", rdBusy(1), 32'h1);
        bus.flush_i = 1'b1;
        setWrite(0, 6, 32'h66);
        #1;
        checkOutput("flush_not_yet", rdBusy(0), 32'h1);
        tick();
        applyStimulus();
        #1;
        checkOutput("flush_x9", rdBusy(0), 32'h0);
        checkOutput("flush_x2", rdBusy(1), 32'h0);
        setRead(0, 6);
        #1;
        checkOutput("flush_write_x6", rdData(0), 32'h66);

        // 6: mid-operation reset drops a concurrent write
        setWrite(0, 1, 32'h101);
        setWrite(1, 2, 32'h202);
        tick();
        applyStimulus();
        setIssue(2);
        tick();
        applyStimulus();
        setRead(0, 1);
        setRead(1, 2);
        #1;
        checkOutput("pre_rst_x1", rdData(0), 32'h101);
        checkOutput("pre_rst_x2_busy", rdBusy(1), 32'h1);
        rst = 1'b1;
        setWrite(0, 1, 32'hFFFF);
        #1;
        checkOutput("in_rst_data", rdData(0), 32'h0);
        checkOutput("in_rst_busy", rdBusy(1), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus();
        #1;
        checkOutput("post_rst_x1", rdData(0), 32'h0);
        checkOutput("post_rst_x2", rdData(1), 32'h0);
        checkOutput("post_rst_x2_busy", rdBusy(1), 32'h0);
        setRead(0, 3);
        setRead(1, 4);
        #1;
        checkOutput("post_rst_x3", rdData(0), 32'h0);
        checkOutput("post_rst_x4", rdData(1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_regfile_mp_sb
